reg_ctrl_fsm: RTL

Multi-cycle instruction decode and control sequencer that sits directly upstream of the 8-bit register file (regd).
- Accepts one 16-bit instruction at a time.
- Drives the register-file read addresses (ra1, ra2), write address (wa), write data (wd) and regwrite.
- Sequences the external combinational ALU and an external data memory.
- Register-file read data (rd1, rd2) goes straight to the ALU. This block only forwards rd2 as store data.

---
 rtl/reg_ctrl_fsm.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/reg_ctrl_fsm.sv
// Instruction decode and control sequencer in front of the 8-bit register file.
// Walks IDLE -> DECODE -> EXEC -> (MEM) -> (WB) for one 16-bit instruction at a time.
module reg_ctrl_fsm #(
  parameter int DATA_W      = 8,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [2:0]        ra1,
  output logic [2:0]        ra2,
  output logic [7:0]        wa,
  output logic [DATA_W-1:0] wd,
  output logic              regwrite,
  output logic [1:0]        alu_op,
  output logic              alu_src_imm,
  output logic [DATA_W-1:0] imm_ext,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] rd2,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err,
  output logic [2:0]        dbg_state
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_ADDI = 4'd5;
  localparam logic [3:0] OP_LD   = 4'd6;
  localparam logic [3:0] OP_ST   = 4'd7;
  localparam logic [3:0] OP_LI   = 4'd8;

  state_t              state, state_n;
  logic [15:0]         ir;
  logic [DATA_W-1:0]   res_q;
  logic [DATA_W-1:0]   sdata_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                err_q;

  logic [3:0]          opcode;
  logic [2:0]          rd_f, rs1_f, rs2_f;
  logic                legal, is_ld, is_st, mem_timeout;

  assign opcode      = ir[15:12];
  assign rd_f        = ir[11:9];
  assign rs1_f       = ir[8:6];
  assign rs2_f       = ir[5:3];
  assign legal       = (opcode <= OP_LI);
  assign is_ld       = (opcode == OP_LD);
  assign is_st       = (opcode == OP_ST);
  assign mem_timeout = (cnt_q == CNT_W'(MEM_TIMEOUT - 1));
  assign err         = err_q;
  assign dbg_state   = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      ir      <= '0;
      res_q   <= '0;
      sdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            ir    <= instr;
            err_q <= 1'b0;
          end
        end
        S_DECODE: begin
          if (!legal) err_q <= 1'b1;
        end
        S_EXEC: begin
          res_q <= (opcode == OP_LI) ? DATA_W'(ir[7:0]) : alu_result;
          if (is_st) sdata_q <= rd2;
          cnt_q <= '0;
        end
        S_MEM: begin
          // cnt_q counts MEM cycles already spent without an ack
          if (mem_ack) begin
            if (is_ld) res_q <= mem_rdata;
          end else if (mem_timeout) begin
            err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake: an instruction transfers on a rising edge where instr_valid and
  // instr_ready are both high; a valid held while busy is ignored, not queued.
  always_comb begin
    state_n     = state;
    instr_ready = 1'b0;
    ra1         = '0;
    ra2         = '0;
    wa          = '0;
    wd          = '0;
    regwrite    = 1'b0;
    alu_op      = 2'b00;
    alu_src_imm = 1'b0;
    imm_ext     = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;

    if (state != S_IDLE) begin
      ra1 = rs1_f;
      ra2 = is_st ? rd_f : rs2_f;
    end

    case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_n = S_DECODE;
      end
      S_DECODE: begin
        state_n = legal ? S_EXEC : S_IDLE;
      end
      S_EXEC: begin
        case (opcode)
          OP_SUB:  alu_op = 2'b01;
          OP_AND:  alu_op = 2'b10;
          OP_OR:   alu_op = 2'b11;
          default: alu_op = 2'b00;
        endcase
        alu_src_imm = (opcode == OP_ADDI) || is_ld || is_st;
        imm_ext     = DATA_W'($signed(ir[5:0]));
        if (is_ld || is_st)        state_n = S_MEM;
        else if (opcode == OP_NOP) state_n = S_IDLE;
        else                       state_n = S_WB;
      end
      S_MEM: begin
        mem_req   = 1'b1;
        mem_we    = is_st;
        mem_addr  = res_q;
        mem_wdata = is_st ? sdata_q : '0;
        if (mem_ack)          state_n = is_ld ? S_WB : S_IDLE;
        else if (mem_timeout) state_n = S_IDLE;
      end
      S_WB: begin
        wa       = {5'b0, rd_f};
        wd       = res_q;
        regwrite = (rd_f != 3'd0);
        state_n  = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule
